// File: rtl/serdes_pkg.sv
// serdes_pkg: shared constants and helpers for the SIPO/PISO serialiser family.
package serdes_pkg;
   localparam bit BIT_ORDER_LSB = 1'b1;
   localparam bit BIT_ORDER_MSB = 1'b0;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/sipo_deser_word_if.sv
// sipo_deser_word_if: serial input, word handshake and overflow signals of the deserialiser.
interface sipo_deser_word_if #(parameter int WIDTH = 8);
   import serdes_pkg::*;
   localparam int CNT_W = clog2(WIDTH);
   logic             ena;
   logic             data_in;
   logic             sync;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] bit_cnt;
   logic             overflow;
   logic             clr_ovf;
   modport master (output ena, data_in, sync, out_ready, clr_ovf,
                   input data_out, out_valid, bit_cnt, overflow);
   modport slave (input ena, data_in, sync, out_ready, clr_ovf,
                  output data_out, out_valid, bit_cnt, overflow);
endinterface

// File: rtl/serial_shift_core.sv
// serial_shift_core: shift register and bit counter with frame-sync clear; pulses done_o with the completed word.
module serial_shift_core
   import serdes_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = BIT_ORDER_LSB,
   localparam int CNT_W    = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             ena_i,
   input  logic             data_i,
   input  logic             sync_i,
   output logic [WIDTH-1:0] word_o,
   output logic             done_o,
   output logic [CNT_W-1:0] cnt_o
);
   logic [WIDTH-1:0] sr_q, sr_d, sr_base;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
   // sync clears first so a simultaneous strobe becomes bit 0 of the new frame
   always_comb begin
      sr_base  = sync_i ? '0 : sr_q;
      cnt_base = sync_i ? '0 : cnt_q;
      word_o   = LSB_FIRST ? {data_i, sr_base[WIDTH-1:1]} : {sr_base[WIDTH-2:0], data_i};
      done_o   = ena_i && (cnt_base == CNT_W'(WIDTH - 1));
      sr_d     = ena_i ? word_o : sr_base;
      cnt_d    = ena_i ? (done_o ? '0 : cnt_base + 1'b1) : cnt_base;
   end
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end
   assign cnt_o = cnt_q;
endmodule

// File: rtl/sipo_deser_word.sv
// sipo_deser_word: serial-to-parallel word deserialiser with one-entry valid/ready holding register and sticky overflow.
module sipo_deser_word
   import serdes_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = BIT_ORDER_LSB
) (
   input logic                clk,
   input logic                clr_n,
   sipo_deser_word_if.slave   bus
);
   logic [WIDTH-1:0] word, data_q, data_d;
   logic             done, load, drop;
   logic             valid_q, valid_d, ovf_q, ovf_d;
   serial_shift_core #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_core (
      .clk    (clk),
      .clr_n  (clr_n),
      .ena_i  (bus.ena),
      .data_i (bus.data_in),
      .sync_i (bus.sync),
      .word_o (word),
      .done_o (done),
      .cnt_o  (bus.bit_cnt)
   );
   // a word completing while the holder is full and not draining is dropped
   always_comb begin
      load    = done && (!valid_q || bus.out_ready);
      drop    = done && valid_q && !bus.out_ready;
      data_d  = load ? word : data_q;
      valid_d = load || (valid_q && !bus.out_ready);
      ovf_d   = drop || (ovf_q && !bus.clr_ovf);
   end
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end
   assign bus.data_out  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sipo_deser_word.sv
// tb_sipo_deser_word: drives LSB-first and MSB-first instances in lockstep against a bit-list reference model.
module tb_sipo_deser_word;
   import serdes_pkg::*;
   localparam int W = 8;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   int total = 0;
   int bad = 0;
   bit m_bits[W];
   int m_cnt = 0;
   logic [W-1:0] m_dl = '0, m_dm = '0;
   bit m_v = 1'b0, m_ovf = 1'b0;
   always #5 clk = ~clk;
   sipo_deser_word_if #(.WIDTH(W)) bl ();
   sipo_deser_word_if #(.WIDTH(W)) bm ();
   sipo_deser_word #(.WIDTH(W), .LSB_FIRST(BIT_ORDER_LSB)) u_lsb (.clk(clk), .clr_n(clr_n), .bus(bl));
   sipo_deser_word #(.WIDTH(W), .LSB_FIRST(BIT_ORDER_MSB)) u_msb (.clk(clk), .clr_n(clr_n), .bus(bm));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic model(input bit e, input bit d, input bit s, input bit r, input bit c, input bit n);
      bit done, drop;
      logic [W-1:0] wl, wm;
      done = 1'b0;
      drop = 1'b0;
      wl = '0;
      wm = '0;
      if (!n) begin
         m_cnt = 0;
         m_v   = 1'b0;
         m_ovf = 1'b0;
         m_dl  = '0;
         m_dm  = '0;
      end else begin
         if (s) m_cnt = 0;
         if (e) begin
            m_bits[m_cnt] = d;
            m_cnt++;
            if (m_cnt == W) begin
               done  = 1'b1;
               m_cnt = 0;
               for (int i = 0; i < W; i++) begin
                  wl[i]       = m_bits[i];
                  wm[W-1-i]   = m_bits[i];
               end
            end
         end
         if (done && m_v && !r) drop = 1'b1;
         else if (done) begin
            m_dl = wl;
            m_dm = wm;
            m_v  = 1'b1;
         end else if (m_v && r) m_v = 1'b0;
         m_ovf = drop || (m_ovf && !c);
      end
   endtask
   task automatic step(input bit e, input bit d, input bit s, input bit r, input bit c, input bit n = 1'b1);
      bl.ena = e; bl.data_in = d; bl.sync = s; bl.out_ready = r; bl.clr_ovf = c;
      bm.ena = e; bm.data_in = d; bm.sync = s; bm.out_ready = r; bm.clr_ovf = c;
      clr_n = n;
      @(posedge clk);
      model(e, d, s, r, c, n);
      #1;
      chk("l_data", bl.data_out, m_dl);
      chk("l_valid", bl.out_valid, m_v);
      chk("l_cnt", bl.bit_cnt, m_cnt);
      chk("l_ovf", bl.overflow, m_ovf);
      chk("m_data", bm.data_out, m_dm);
      chk("m_valid", bm.out_valid, m_v);
      chk("m_cnt", bm.bit_cnt, m_cnt);
      chk("m_ovf", bm.overflow, m_ovf);
   endtask
   task automatic send_word(input logic [W-1:0] w, input bit rdy_last = 1'b0, input bit clr_last = 1'b0,
                            input bit sync_first = 1'b0);
      for (int i = 0; i < W; i++)
         step(1'b1, w[i], sync_first && i == 0, rdy_last && i == W - 1, clr_last && i == W - 1);
   endtask
   initial begin
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("rst_valid", bl.out_valid, 0);
      chk("rst_data", bl.data_out, 0);
      // basic word in both bit orders
      send_word(8'h1E);
      chk("t1_data_lsb", bl.data_out, 8'h1E);
      chk("t1_data_msb", bm.data_out, 8'h78);
      chk("t1_valid", bl.out_valid, 1);
      chk("t1_cnt", bl.bit_cnt, 0);
      step(0, 0, 0, 1, 0);
      chk("t1_drained", bl.out_valid, 0);
      // overflow while stalled, clear, and set-beats-clear
      send_word(8'h1E);
      send_word(8'h55);
      chk("t3_hold", bl.data_out, 8'h1E);
      chk("t3_ovf", bl.overflow, 1);
      step(0, 0, 0, 0, 1);
      chk("t3_clr", bl.overflow, 0);
      send_word(8'h55, 1'b0, 1'b1);
      chk("t3_set_wins", bl.overflow, 1);
      chk("t3_hold2", bl.data_out, 8'h1E);
      step(0, 0, 0, 0, 0, 0);
      // completion on the same edge as a transfer
      send_word(8'h1E);
      send_word(8'h55, 1'b1);
      chk("t4_valid", bl.out_valid, 1);
      chk("t4_data", bl.data_out, 8'h55);
      chk("t4_ovf", bl.overflow, 0);
      step(0, 0, 0, 1, 0);
      // frame sync discards partial bits
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("t5_sync_cnt", bl.bit_cnt, 0);
      send_word(8'hA3);
      chk("t5_data", bl.data_out, 8'hA3);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
      send_word(8'hA3, 1'b0, 1'b0, 1'b1);
      chk("t5_sync_ena", bl.data_out, 8'hA3);
      chk("t5_ovf", bl.overflow, 0);
      // reset mid-word with a pending word
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0);
      chk("t6_data", bl.data_out, 0);
      chk("t6_valid", bl.out_valid, 0);
      chk("t6_cnt", bl.bit_cnt, 0);
      chk("t6_ovf", bl.overflow, 0);
      send_word(8'h0F);
      chk("t6_word_lsb", bl.data_out, 8'h0F);
      chk("t6_word_msb", bm.data_out, 8'hF0);
      // random traffic
      for (int k = 0; k < 800; k++)
         step($urandom_range(0, 9) < 6, 1'($urandom), $urandom_range(0, 15) == 0, 1'($urandom),
              $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
